// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor family.
//   sub_state_t       : FSM state encoding (IDLE, RUN, DONE)
//   SUB_DEFAULT_WIDTH : default operand width
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs.sv
// fs: combinational full subtractor, computes a - b - bin.
// Built from two half subtractors: the first forms a - b, the second
// subtracts bin from that partial difference. At most one stage can
// borrow, so the two borrows are simply OR-ed.
// Ports:
//   a, b, bin in  : minuend, subtrahend, borrow-in bits
//   different out : a ^ b ^ bin
//   borrow    out : (~a & b) | (~(a ^ b) & bin)
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic different,
  output logic borrow
);

  logic d1;
  logic b1;
  logic b2;

  hs u_hs0 (
    .a         (a),
    .b         (b),
    .different (d1),
    .borrow    (b1)
  );

  hs u_hs1 (
    .a         (d1),
    .b         (bin),
    .different (different),
    .borrow    (b2)
  );

  assign borrow = b1 | b2;

endmodule

// File: rtl/hs.sv
// hs: combinational half subtractor, computes a - b.
// Ports:
//   a, b      in  : minuend / subtrahend bits
//   different out : a ^ b
//   borrow    out : ~a & b
module hs (
  input  logic a,
  input  logic b,
  output logic different,
  output logic borrow
);

  assign different = a ^ b;
  assign borrow    = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, a - b - bin, LSB
// first, one bit per clock through a single fs cell.
// Optional feature macro: SERSUB_OVERFLOW_EN (adds the overflow output).
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   start      in  : request, honoured only in IDLE and DONE
//   a, b       in  : minuend / subtrahend, latched on an accepted start
//   bin        in  : borrow-in, latched on an accepted start
//   busy       out : high while bits are being processed
//   done       out : one-cycle pulse when a new result is presented
//   different  out : difference modulo 2^WIDTH, held until next completion
//   borrow     out : final borrow-out, held with different
//   overflow   out : signed overflow (only with SERSUB_OVERFLOW_EN)
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] different,
`ifdef SERSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             br;
  logic [CW-1:0]    count;
  logic             d;
  logic             bo;

`ifdef SERSUB_OVERFLOW_EN
  // Operand MSBs are shifted out of sa/sb, so keep a copy for the
  // overflow decision at the end of the run.
  logic a_msb;
  logic b_msb;
`endif

  fs u_fs (
    .a         (sa[0]),
    .b         (sb[0]),
    .bin       (br),
    .different (d),
    .borrow    (bo)
  );

  // Accumulator after this cycle's bit: shift right, new bit enters at
  // the MSB. Written this way so WIDTH=1 needs no special case.
  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      different <= '0;
      borrow    <= 1'b0;
      count     <= '0;
      sa        <= '0;
      sb        <= '0;
      acc       <= '0;
      br        <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      overflow  <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            br    <= bin;
            count <= '0;
            acc   <= '0;
`ifdef SERSUB_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          acc   <= acc_next;
          br    <= bo;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            different <= acc_next;
            borrow    <= bo;
`ifdef SERSUB_OVERFLOW_EN
            // d is the result MSB on the final bit.
            overflow  <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       brw;
    logic       ovf;
    int         issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       brw8;
`ifdef SERSUB_OVERFLOW_EN
  logic       ovf8;
  logic       ovf1;
`endif

  // WIDTH=1 instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       brw1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .busy      (busy8),
    .done      (done8),
    .different (diff8),
`ifdef SERSUB_OVERFLOW_EN
    .overflow  (ovf8),
`endif
    .borrow    (brw8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .busy      (busy1),
    .done      (done1),
    .different (diff1),
`ifdef SERSUB_OVERFLOW_EN
    .overflow  (ovf1),
`endif
    .borrow    (brw1)
  );

  exp_t q8[$];
  exp_t q1[$];
  int   busy_cnt8 = 0;
  int   busy_cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input int issue);
    exp_t e;
    int   ai, bi, r, m;
    m  = 1 << w;
    ai = int'(a) % m;
    bi = int'(b) % m;
    r  = ai - bi - int'(bin);
    e.a     = a;
    e.b     = b;
    e.bin   = bin;
    e.diff  = 8'((r + 2 * m) % m);
    e.brw   = (ai < bi + int'(bin));
    // signed overflow: operands of opposite sign, result sign differs from a
    e.ovf   = ((ai >= m / 2) != (bi >= m / 2)) && ((int'(e.diff) >= m / 2) != (ai >= m / 2));
    e.issue = issue;
    return e;
  endfunction

  // Monitors: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt8 = 0;
    end else begin
      if (busy8) busy_cnt8++;
      if (done8) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 32'(done8), 32'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("diff8", 32'(diff8), 32'(e.diff));
          chk("borrow8", 32'(brw8), 32'(e.brw));
          chk("latency8", 32'(cyc - e.issue), 32'd9);
          chk("busy_len8", 32'(busy_cnt8), 32'd8);
`ifdef SERSUB_OVERFLOW_EN
          chk("overflow8", 32'(ovf8), 32'(e.ovf));
`endif
          $display("txn w=8 a=%02h b=%02h bin=%0b -> diff=%02h borrow=%0b lat=%0d",
                   e.a, e.b, e.bin, diff8, brw8, cyc - e.issue);
        end
        busy_cnt8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt1 = 0;
    end else begin
      if (busy1) busy_cnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          chk("spurious_done1", 32'(done1), 32'd0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("diff1", 32'(diff1), 32'(e.diff));
          chk("borrow1", 32'(brw1), 32'(e.brw));
          chk("latency1", 32'(cyc - e.issue), 32'd2);
          chk("busy_len1", 32'(busy_cnt1), 32'd1);
          $display("txn w=1 a=%0b b=%0b bin=%0b -> diff=%0b borrow=%0b lat=%0d",
                   e.a[0], e.b[0], e.bin, diff1, brw1, cyc - e.issue);
        end
        busy_cnt1 = 0;
      end
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back(model(8, a, b, bin, cyc - 1));
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge clk);
    if (q8.size() != 0) begin
      chk("timeout8", 32'(q8.size()), 32'd0);
      q8.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic go1(input logic a, input logic b, input logic bin);
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    q1.push_back(model(1, {7'd0, a}, {7'd0, b}, bin, cyc - 1));
  endtask

  task automatic drain1();
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(posedge clk);
    if (q1.size() != 0) begin
      chk("timeout1", 32'(q1.size()), 32'd0);
      q1.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_done"}, 32'(done8), 32'd0);
    chk({tag, "_diff"}, 32'(diff8), 32'd0);
    chk({tag, "_borrow"}, 32'(brw8), 32'd0);
`ifdef SERSUB_OVERFLOW_EN
    chk({tag, "_overflow"}, 32'(ovf8), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero8("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    go8(8'h05, 8'h03, 1'b0); drain8();
    go8(8'h03, 8'h05, 1'b0); drain8();
    go8(8'h00, 8'h00, 1'b1); drain8();
    go8(8'h80, 8'h01, 1'b0); drain8();
    go8(8'h7F, 8'h01, 1'b0); drain8();
    go8(8'hFF, 8'hFF, 1'b1); drain8();

    // Start during RUN is ignored
    go8(8'h10, 8'h01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain8();

    // Reset in the 4th RUN cycle aborts; no done must follow
    go8(8'h5A, 8'h33, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    chk_zero8("abort");
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    go8(8'hC3, 8'h3C, 1'b1); drain8();

    // Back-to-back with start held high
    start8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(posedge clk); #1;
      q8.push_back(model(8, a8, b8, bin8, cyc - 1));
      repeat (8) @(posedge clk);
      #1;
    end
    start8 = 1'b0;
    drain8();

    // Random transactions with random idle gaps
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      go8(8'($urandom), 8'($urandom), 1'($urandom));
      drain8();
    end

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      go1(v[2], v[1], v[0]);
      drain1();
    end

    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
